fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding, decode NOP and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DEF_OPCODEWIDTH = 4;
  localparam int unsigned DEF_INSTRWIDTH  = 32;
  localparam int unsigned DEF_PCWIDTH     = 16;
  localparam int unsigned FETCH_CNT_WIDTH = 16;

  localparam logic [3:0] NOP_OPCODE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing against a 1-cycle synchronous ROM, IF/ID register,
// stall hold, branch redirect with two-bubble flush, halt, and delivered-instruction counter.
module fetch_unit #(
  parameter int unsigned OPCODEWIDTH = fetch_pkg::DEF_OPCODEWIDTH,
  parameter int unsigned INSTRWIDTH  = fetch_pkg::DEF_INSTRWIDTH,
  parameter int unsigned PCWIDTH     = fetch_pkg::DEF_PCWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startI,
  input  logic                   haltI,
  input  logic                   stallF,
  input  logic                   branchTakenE,
  input  logic [PCWIDTH-1:0]     branchTargetE,
  output logic [PCWIDTH-1:0]     imemAddrF,
  input  logic [INSTRWIDTH-1:0]  imemDataF,
  output logic [INSTRWIDTH-1:0]  instrD,
  output logic [OPCODEWIDTH-1:0] opcodeD,
  output logic [PCWIDTH-1:0]     pcD,
  output logic                   validD,
  output logic [15:0]            fetchCountO,
  output logic [1:0]             stateO
);
  import fetch_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [PCWIDTH-1:0]         r_pc_f;
  logic [PCWIDTH-1:0]         r_pend_pc;
  logic                       r_pend_valid;
  logic [INSTRWIDTH-1:0]      r_instr_d;
  logic [PCWIDTH-1:0]         r_pc_d;
  logic                       r_valid_d;
  logic [FETCH_CNT_WIDTH-1:0] r_fetch_cnt;

  logic w_advance;
  logic w_flush;
  logic w_halt_entry;
  logic w_clear;
  logic [PCWIDTH-1:0] w_pc_inc;

  assign w_pc_inc = r_pc_f + PCWIDTH'(1);

  // Next state and per-edge datapath action; branch outranks stall, halt suppresses advance.
  always_comb begin
    w_state_nxt  = r_state;
    w_advance    = 1'b0;
    w_flush      = 1'b0;
    w_halt_entry = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (startI) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (haltI) begin
          w_state_nxt  = ST_HALT;
          w_halt_entry = 1'b1;
        end
        if (branchTakenE) w_flush = 1'b1;
        else if (!stallF && !haltI) w_advance = 1'b1;
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: begin
        w_state_nxt = ST_IDLE;
        w_clear     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Fetch pipeline: pcF -> pending ROM word -> IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f       <= '0;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
      r_instr_d    <= '0;
      r_pc_d       <= '0;
      r_valid_d    <= 1'b0;
      r_fetch_cnt  <= '0;
    end else if (w_clear) begin
      r_pc_f       <= '0;
      r_pend_valid <= 1'b0;
      r_valid_d    <= 1'b0;
      r_instr_d    <= '0;
    end else if (w_flush || w_halt_entry) begin
      if (w_flush) r_pc_f <= branchTargetE;
      r_pend_valid <= 1'b0;
      r_valid_d    <= 1'b0;
      r_instr_d    <= '0;
    end else if (w_advance) begin
      r_instr_d    <= r_pend_valid ? imemDataF : '0;
      r_pc_d       <= r_pend_pc;
      r_valid_d    <= r_pend_valid;
      r_pend_pc    <= r_pc_f;
      r_pend_valid <= 1'b1;
      r_pc_f       <= w_pc_inc;
      if (r_pend_valid) r_fetch_cnt <= r_fetch_cnt + FETCH_CNT_WIDTH'(1);
    end
  end

  // While stalled the ROM re-reads the pending word so its data is still there on release.
  assign imemAddrF   = (r_state == ST_RUN && stallF) ? r_pend_pc : r_pc_f;
  assign instrD      = r_instr_d;
  assign opcodeD     = r_instr_d[INSTRWIDTH-1 -: OPCODEWIDTH];
  assign pcD         = r_pc_d;
  assign validD      = r_valid_d;
  assign fetchCountO = r_fetch_cnt;
  assign stateO      = r_state;

endmodule
